// File: rtl/chunk_line_fetcher.sv
// Line fetch front end: issues LINE_LEN store reads and assembles the returned line.
// Optional: CHUNK_FETCH_OOB_AIR_EN forces out-of-bounds entries to air (5'd0).
module chunk_line_fetcher #(
    parameter int LINE_LEN     = 8,
    parameter int READ_LATENCY = 2,
    parameter int CHUNK_WIDTH  = 16,
    parameter int COORD_W      = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3*COORD_W-1:0]    req_pos,
    output logic [3*COORD_W-1:0]    mem_addr,
    output logic                    mem_read_enable,
    input  logic [4:0]              mem_data,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic [3*COORD_W-1:0]    line_pos,
    output logic [5*LINE_LEN-1:0]   line_data,
    output logic [LINE_LEN-1:0]     line_oob
);

    localparam int LB    = $clog2(LINE_LEN);
    localparam int CNT_W = LB;
    localparam logic signed [COORD_W-1:0] C_LO = COORD_W'(-CHUNK_WIDTH);
    localparam logic signed [COORD_W-1:0] C_HI = COORD_W'(CHUNK_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [3*COORD_W-1:0]   r_base;
    logic [3*COORD_W-1:0]   r_mem_addr;
    logic                   r_mem_re;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [COORD_W-1:0]     w_x_nxt;
    logic [3*COORD_W-1:0]   w_base;

    logic [READ_LATENCY-1:0] r_tag_v;
    logic [CNT_W-1:0]        r_tag_idx [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_tag_oob;

    logic [4:0]             r_line [LINE_LEN];
    logic [LINE_LEN-1:0]    r_line_oob;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_busy;
    logic                   w_oob;
    logic [4:0]             w_wdata;

    function automatic logic axis_oob(input logic signed [COORD_W-1:0] a);
        return (a < C_LO) || (a > C_HI);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_last    = (r_cnt == CNT_W'(LINE_LEN - 1));
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_x_nxt   = r_base[3*COORD_W-1:2*COORD_W] + COORD_W'(w_cnt_nxt);

    assign w_oob = axis_oob(r_mem_addr[3*COORD_W-1:2*COORD_W])
                 | axis_oob(r_mem_addr[2*COORD_W-1:COORD_W])
                 | axis_oob(r_mem_addr[COORD_W-1:0]);

    always_comb begin
        w_base = req_pos;
        w_base[2*COORD_W +: LB] = '0;
    end

    // Only the head stage may still hold a tag when the drain completes
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            w_busy = w_busy | r_tag_v[i];
        end
    end

    always_comb begin
`ifdef CHUNK_FETCH_OOB_AIR_EN
        w_wdata = r_tag_oob[READ_LATENCY-1] ? 5'd0 : mem_data;
`else
        w_wdata = mem_data;
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (req_valid)  w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_last)     w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_busy)    w_state_nxt = S_DONE;
            S_DONE:  if (line_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_base     <= '0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_cnt      <= '0;
            r_tag_v    <= '0;
            r_tag_oob  <= '0;
            r_line_oob <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_idx[i] <= '0;
            end
            for (int i = 0; i < LINE_LEN; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_tag_v[0]   <= r_mem_re;
            r_tag_idx[0] <= r_cnt;
            r_tag_oob[0] <= w_oob;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
                r_tag_oob[i] <= r_tag_oob[i-1];
            end

            if (w_accept) begin
                r_base     <= w_base;
                r_mem_addr <= w_base;
                r_mem_re   <= 1'b1;
                r_cnt      <= '0;
                r_line_oob <= '0;
            end else if (r_state == S_ISSUE) begin
                if (w_last) begin
                    r_mem_re <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                    r_mem_addr <= {w_x_nxt, r_base[2*COORD_W-1:0]};
                end
            end

            if (r_tag_v[READ_LATENCY-1]) begin
                r_line[r_tag_idx[READ_LATENCY-1]]     <= w_wdata;
                r_line_oob[r_tag_idx[READ_LATENCY-1]] <= r_tag_oob[READ_LATENCY-1];
            end
        end
    end

    always_comb begin
        line_data = '0;
        for (int i = 0; i < LINE_LEN; i++) begin
            line_data[5*i +: 5] = r_line[i];
        end
    end

    assign req_ready       = (r_state == S_IDLE);
    assign line_valid      = (r_state == S_DONE);
    assign mem_addr        = r_mem_addr;
    assign mem_read_enable = r_mem_re;
    assign line_pos        = r_base;
    assign line_oob        = r_line_oob;

endmodule

// File: tb/tb_chunk_line_fetcher.sv
// Directed + randomized bench for chunk_line_fetcher with a fixed-latency store model.
module tb_chunk_line_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_pos = '0;
    logic [23:0] mem_addr;
    logic        mem_read_enable;
    logic [4:0]  mem_data;
    logic        line_valid;
    logic        line_ready = 1'b0;
    logic [23:0] line_pos;
    logic [39:0] line_data;
    logic [7:0]  line_oob;

    int n_vec = 0;
    int n_err = 0;
    int seed;

    logic [39:0] exp_data;
    logic [7:0]  exp_oob;
    logic [23:0] exp_pos;

    always #5 clk_in = ~clk_in;

    chunk_line_fetcher dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pos         (req_pos),
        .mem_addr        (mem_addr),
        .mem_read_enable (mem_read_enable),
        .mem_data        (mem_data),
        .line_valid      (line_valid),
        .line_ready      (line_ready),
        .line_pos        (line_pos),
        .line_data       (line_data),
        .line_oob        (line_oob)
    );

    function automatic bit out_rng(input logic signed [7:0] a);
        return (int'(a) < -16) || (int'(a) > 15);
    endfunction

    function automatic bit pos_oob(input logic [23:0] p);
        return out_rng(p[23:16]) || out_rng(p[15:8]) || out_rng(p[7:0]);
    endfunction

    function automatic logic [4:0] hash(input logic [23:0] p);
        int v;
        v = int'($signed(p[23:16])) * 3 + int'($signed(p[15:8])) * 7
          + int'($signed(p[7:0])) * 11 + seed;
        return 5'(v);
    endfunction

    // Store: out-of-bounds addresses alias to slot 0
    function automatic logic [4:0] store_val(input logic [23:0] p);
        return pos_oob(p) ? hash(24'd0) : hash(p);
    endfunction

    logic [4:0] st_p1, st_p2;
    always @(posedge clk_in) begin
        st_p1 <= store_val(mem_addr);
        st_p2 <= st_p1;
    end
    assign mem_data = st_p2;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [23:0] mkpos(input int x, input int y, input int z);
        return {8'(x), 8'(y), 8'(z)};
    endfunction

    // Drives a request at the current negedge and follows it to line_valid
    task automatic run_line(input logic [23:0] p);
        logic [7:0]  bx;
        logic [23:0] a;
        bit          o;
        bx = p[23:16] & 8'hF8;
        exp_pos = {bx, p[15:0]};
        for (int i = 0; i < 8; i++) begin
            a = {8'(bx + 8'(i)), p[15:0]};
            o = pos_oob(a);
            exp_oob[i] = o;
`ifdef CHUNK_FETCH_OOB_AIR_EN
            exp_data[5*i +: 5] = o ? 5'd0 : hash(a);
`else
            exp_data[5*i +: 5] = o ? hash(24'd0) : hash(a);
`endif
        end
        req_pos = p;
        req_valid = 1'b1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rd_en", 64'(mem_read_enable), 64'd1);
            chk("rd_addr", 64'(mem_addr), 64'({8'(bx + 8'(i)), p[15:0]}));
            chk("lv_early", 64'(line_valid), 64'd0);
            chk("busy", 64'(req_ready), 64'd0);
            line_ready = 1'($urandom_range(0, 1));
            @(negedge clk_in);
        end
        line_ready = 1'b0;
        chk("rd_en_off", 64'(mem_read_enable), 64'd0);
        chk("addr_hold", 64'(mem_addr), 64'({8'(bx + 8'd7), p[15:0]}));
        chk("lv_t9", 64'(line_valid), 64'd0);
        @(negedge clk_in);
        chk("lv_t10", 64'(line_valid), 64'd0);
        @(negedge clk_in);
        chk("lv_t11", 64'(line_valid), 64'd1);
        chk("line_pos", 64'(line_pos), 64'(exp_pos));
        chk("line_data", 64'(line_data), 64'(exp_data));
        chk("line_oob", 64'(line_oob), 64'(exp_oob));
        chk("req_ready_done", 64'(req_ready), 64'd0);
    endtask

    task automatic handshake(input int hold);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_in);
            chk("bp_lv", 64'(line_valid), 64'd1);
            chk("bp_data", 64'(line_data), 64'(exp_data));
            chk("bp_oob", 64'(line_oob), 64'(exp_oob));
            chk("bp_pos", 64'(line_pos), 64'(exp_pos));
            chk("bp_rdy", 64'(req_ready), 64'd0);
            chk("bp_rd", 64'(mem_read_enable), 64'd0);
        end
        line_ready = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        line_ready = 1'b0;
        chk("hs_lv_low", 64'(line_valid), 64'd0);
        chk("hs_rdy", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int acc [$];
        int cyc;
        int pulses;
        bit prev_lv;
        logic [23:0] p;

        seed = $urandom_range(1, 31);
        #2;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rd", 64'(mem_read_enable), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_lv", 64'(line_valid), 64'd0);
        chk("rst_data", 64'(line_data), 64'd0);
        chk("rst_oob", 64'(line_oob), 64'd0);
        chk("rst_pos", 64'(line_pos), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        run_line(mkpos(5, 3, -2));
        handshake(0);
        run_line(mkpos(12, 0, 0));
        handshake(1);
        run_line(mkpos(16, 0, 0));
        handshake(0);
        run_line(mkpos(-16, -17, 0));
        handshake(2);

        // Backpressure with a pending request that must wait
        run_line(mkpos(-3, 7, 15));
        req_pos = mkpos(9, -5, 4);
        req_valid = 1'b1;
        handshake(20);
        run_line(mkpos(9, -5, 4));
        handshake(0);

        for (int r = 0; r < 6; r++) begin
            p = mkpos($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20,
                      $urandom_range(0, 40) - 20);
            run_line(p);
            handshake($urandom_range(0, 3));
        end

        // Abort while the fifth read is issuing
        req_pos = mkpos(-8, 2, 2);
        req_valid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("abort_rd", 64'(mem_read_enable), 64'd1);
        chk("abort_addr", 64'(mem_addr), 64'(mkpos(-4, 2, 2)));
        #2 rst_in = 1'b1;
        #1;
        chk("arst_ready", 64'(req_ready), 64'd1);
        chk("arst_rd", 64'(mem_read_enable), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_lv", 64'(line_valid), 64'd0);
        chk("arst_data", 64'(line_data), 64'd0);
        chk("arst_oob", 64'(line_oob), 64'd0);
        chk("arst_pos", 64'(line_pos), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        run_line(mkpos(8, 1, 1));
        handshake(0);

        // Back-to-back with line_ready tied high
        req_valid = 1'b1;
        line_ready = 1'b1;
        req_pos = mkpos(1, 1, 1);
        prev_lv = 1'b0;
        pulses = 0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (req_valid && req_ready) acc.push_back(cyc);
            if (line_valid) pulses++;
            chk("lv_pulse", 64'(line_valid && prev_lv), 64'd0);
            prev_lv = line_valid;
            @(negedge clk_in);
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 64'(acc.size() >= 3), 64'd1);
        chk("b2b_pulses", 64'(pulses >= 2), 64'd1);
        for (int k = 1; k < acc.size(); k++) begin
            chk("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'd12);
        end
        repeat (20) @(negedge clk_in);
        chk("b2b_idle", 64'(req_ready), 64'd1);
        line_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
